// File: rtl/audio_pkg.sv
// Shared types and constants for the audio voice scheduler.
package audio_pkg;

    localparam int unsigned AV_NUM_VOICES = 4;
    localparam int unsigned AV_ADDR_W     = 16;
    localparam int unsigned AV_SAMPLE_W   = 8;
    localparam int unsigned AV_OUT_W      = 16;
    localparam int unsigned AV_ROM_LAT    = 1;

    // Accumulator holds the full sum of every voice, so it never wraps.
    localparam int unsigned AV_ACC_W      = AV_OUT_W + $clog2(AV_NUM_VOICES);

    // Headroom of two bits so a couple of full-scale voices do not clip.
    localparam int unsigned SAMPLE_SHIFT  = AV_OUT_W - AV_SAMPLE_W - 2;

    localparam logic signed [AV_ACC_W-1:0] SAT_MAX =
        AV_ACC_W'((64'd1 << (AV_OUT_W - 1)) - 64'd1);
    localparam logic signed [AV_ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACC,
        DONE
    } state_t;

    typedef struct packed {
        logic [AV_ADDR_W-1:0] base;
        logic [AV_ADDR_W-1:0] len;
        logic [AV_ADDR_W-1:0] pos;
        logic                 active;
    } voice_t;

    // Clamp the wide accumulator into the output sample range.
    function automatic logic [AV_OUT_W-1:0] saturate(input logic signed [AV_ACC_W-1:0] a);
        if (a > SAT_MAX) begin
            return AV_OUT_W'(SAT_MAX);
        end
        if (a < SAT_MIN) begin
            return AV_OUT_W'(SAT_MIN);
        end
        return AV_OUT_W'(a);
    endfunction

endpackage

// File: rtl/lrclk_edge_sync.sv
// Brings codec LRCLK into the Clk domain and emits a one-cycle pulse per rising edge.
module lrclk_edge_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic lrclk,
    output logic tick
);

    logic meta;
    logic sync;
    logic prev;

    // Two-flop synchronizer, edge register, registered rising-edge pulse.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            tick <= 1'b0;
        end else begin
            meta <= lrclk;
            sync <= meta;
            prev <= sync;
            tick <= sync & ~prev;
        end
    end

endmodule

// File: rtl/audio_voice_scheduler.sv
// Per-frame round-robin mixer of one-shot ROM voices with saturating output.
module audio_voice_scheduler
    import audio_pkg::*;
#(
    parameter int unsigned NUM_VOICES = AV_NUM_VOICES,
    parameter int unsigned ADDR_W     = AV_ADDR_W,
    parameter int unsigned SAMPLE_W   = AV_SAMPLE_W,
    parameter int unsigned OUT_W      = AV_OUT_W,
    parameter int unsigned ROM_LAT    = AV_ROM_LAT
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         lrclk,
    input  logic [NUM_VOICES-1:0]        trig,
    input  logic [NUM_VOICES*ADDR_W-1:0] trig_addr,
    input  logic [NUM_VOICES*ADDR_W-1:0] trig_len,
    input  logic [NUM_VOICES-1:0]        stop,
    output logic                         rom_rd,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [SAMPLE_W-1:0]          rom_data,
    output logic [OUT_W-1:0]             mix_sample,
    output logic                         mix_valid,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic                         busy,
    output logic                         overrun
);

    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic                        tick;
    state_t                      state;
    voice_t                      voice [NUM_VOICES];
    logic [NUM_VOICES-1:0]       pend_trig;
    logic [NUM_VOICES-1:0]       pend_stop;
    logic [ADDR_W-1:0]           pend_addr [NUM_VOICES];
    logic [ADDR_W-1:0]           pend_len  [NUM_VOICES];
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            idx_nxt;
    logic                        is_last;
    logic [1:0]                  wcnt;
    logic [SAMPLE_W-1:0]         rom_q;
    logic signed [AV_ACC_W-1:0]  acc;
    logic signed [AV_ACC_W-1:0]  samp_ext;
    logic                        req_direct;

    lrclk_edge_sync u_sync (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .lrclk   (lrclk),
        .tick    (tick)
    );

    // Next-voice index, last-voice flag and the scaled, sign-extended ROM sample.
    always_comb begin
        idx_nxt    = idx + IDX_W'(1);
        is_last    = (idx == IDX_W'(NUM_VOICES - 1));
        samp_ext   = {{(AV_ACC_W - SAMPLE_W){rom_q[SAMPLE_W-1]}}, rom_q} <<< SAMPLE_SHIFT;
        // Requests land directly only outside a frame; a request coinciding with
        // the starting tick is deferred so the frame sees a stable voice table.
        req_direct = ((state == IDLE) && !tick) || (state == DONE);
    end

    // Voice state publishes straight from the voice registers.
    always_comb begin
        voice_active = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_active[i] = voice[i].active;
        end
    end

    // Frame sequencer, ROM fetch, accumulation and trigger/stop bookkeeping.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            wcnt       <= '0;
            rom_q      <= '0;
            acc        <= '0;
            rom_rd     <= 1'b0;
            rom_addr   <= '0;
            mix_sample <= '0;
            mix_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            pend_trig  <= '0;
            pend_stop  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voice[i]     <= '0;
                pend_addr[i] <= '0;
                pend_len[i]  <= '0;
            end
        end else begin
            mix_valid <= 1'b0;
            rom_rd    <= 1'b0;

            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            // The read strobe is set up one edge early so it is high during ISSUE.
            case (state)
                IDLE: begin
                    if (tick) begin
                        acc      <= '0;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                        rom_rd   <= voice[0].active;
                        rom_addr <= voice[0].base + voice[0].pos;
                    end
                end
                ISSUE: begin
                    if (voice[idx].active) begin
                        wcnt  <= '0;
                        state <= WAIT;
                    end else if (is_last) begin
                        state <= DONE;
                    end else begin
                        idx      <= idx_nxt;
                        rom_rd   <= voice[idx_nxt].active;
                        rom_addr <= voice[idx_nxt].base + voice[idx_nxt].pos;
                    end
                end
                WAIT: begin
                    if (wcnt == 2'(ROM_LAT - 1)) begin
                        rom_q <= rom_data;
                        state <= ACC;
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                ACC: begin
                    acc            <= acc + samp_ext;
                    voice[idx].pos <= voice[idx].pos + ADDR_W'(1);
                    if ((voice[idx].pos + ADDR_W'(1)) == voice[idx].len) begin
                        voice[idx].active <= 1'b0;
                    end
                    if (is_last) begin
                        state <= DONE;
                    end else begin
                        idx      <= idx_nxt;
                        state    <= ISSUE;
                        rom_rd   <= voice[idx_nxt].active;
                        rom_addr <= voice[idx_nxt].base + voice[idx_nxt].pos;
                    end
                end
                DONE: begin
                    mix_sample <= saturate(acc);
                    mix_valid  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Fresh requests beat older pending ones; trig beats stop in one cycle.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (req_direct) begin
                    if (trig[i]) begin
                        voice[i].base   <= trig_addr[i*ADDR_W +: ADDR_W];
                        voice[i].len    <= trig_len[i*ADDR_W +: ADDR_W];
                        voice[i].pos    <= '0;
                        voice[i].active <= (trig_len[i*ADDR_W +: ADDR_W] != '0);
                    end else if (stop[i]) begin
                        voice[i].active <= 1'b0;
                    end else if ((state == DONE) && pend_trig[i]) begin
                        voice[i].base   <= pend_addr[i];
                        voice[i].len    <= pend_len[i];
                        voice[i].pos    <= '0;
                        voice[i].active <= (pend_len[i] != '0);
                    end else if ((state == DONE) && pend_stop[i]) begin
                        voice[i].active <= 1'b0;
                    end
                    pend_trig[i] <= 1'b0;
                    pend_stop[i] <= 1'b0;
                end else begin
                    if (trig[i]) begin
                        pend_trig[i] <= 1'b1;
                        pend_stop[i] <= 1'b0;
                        pend_addr[i] <= trig_addr[i*ADDR_W +: ADDR_W];
                        pend_len[i]  <= trig_len[i*ADDR_W +: ADDR_W];
                    end else if (stop[i]) begin
                        pend_trig[i] <= 1'b0;
                        pend_stop[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Scoreboard bench for audio_voice_scheduler with a latency-1 ROM model.
module tb_audio_voice_scheduler;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        lrclk = 1'b0;
    logic [3:0]  trig = '0;
    logic [63:0] trig_addr = '0;
    logic [63:0] trig_len = '0;
    logic [3:0]  stop = '0;
    logic        rom_rd;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic [15:0] mix_sample;
    logic        mix_valid;
    logic [3:0]  voice_active;
    logic        busy;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_addr [$];
    logic [15:0] exp_mix  [$];
    logic [15:0] e_addr;
    logic [15:0] e_mix;
    logic [7:0]  rom_fill = '0;

    audio_voice_scheduler dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .lrclk        (lrclk),
        .trig         (trig),
        .trig_addr    (trig_addr),
        .trig_len     (trig_len),
        .stop         (stop),
        .rom_rd       (rom_rd),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .mix_sample   (mix_sample),
        .mix_valid    (mix_valid),
        .voice_active (voice_active),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #10 Clk = ~Clk;

    function automatic logic [7:0] rom_val(input logic [15:0] a);
        case (a)
            16'h0100: return 8'h10;
            16'h0101: return 8'h20;
            16'h0102: return 8'h7F;
            default:  return rom_fill;
        endcase
    endfunction

    // ROM model: data valid one cycle after the read strobe.
    always @(posedge Clk) begin
        if (rom_rd) rom_data <= rom_val(rom_addr);
    end

    // Scoreboard: every ROM read and every mixed sample must match the queue head.
    always @(negedge Clk) begin
        if (rom_rd) begin
            n_tests++;
            if (exp_addr.size() == 0) begin
                n_fail++;
                $display("FAIL rom_addr: unexpected read at %h, required no read", rom_addr);
            end else begin
                e_addr = exp_addr.pop_front();
                if (rom_addr !== e_addr) begin
                    n_fail++;
                    $display("FAIL rom_addr: got %h, required %h", rom_addr, e_addr);
                end
            end
        end
        if (mix_valid) begin
            n_tests++;
            if (exp_mix.size() == 0) begin
                n_fail++;
                $display("FAIL mix_sample: unexpected mix_valid with %h", mix_sample);
            end else begin
                e_mix = exp_mix.pop_front();
                if (mix_sample !== e_mix) begin
                    n_fail++;
                    $display("FAIL mix_sample: got %h, required %h", mix_sample, e_mix);
                end
            end
        end
    end

    task automatic do_reset();
        Reset_n = 1'b0;
        lrclk   = 1'b0;
        trig    = '0;
        stop    = '0;
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_voice(input int i, input logic [15:0] a, input logic [15:0] l);
        trig_addr[i*16 +: 16] = a;
        trig_len[i*16 +: 16]  = l;
    endtask

    task automatic pulse(input logic [3:0] t, input logic [3:0] s);
        trig = t;
        stop = s;
        @(posedge Clk);
        #1;
        trig = '0;
        stop = '0;
    endtask

    // Raise lrclk and count cycles to mix_valid; optionally inject a busy-time
    // trigger or a second lrclk edge while the frame is running.
    task automatic run_frame(input logic [3:0] bt, input logic dbl,
                             output int lat, output logic got);
        int cnt;
        int inj_cnt;
        logic inj;
        cnt = 0; inj_cnt = 0; inj = 1'b0;
        got = 1'b0; lat = 0;
        lrclk = 1'b1;
        while (cnt < 200 && !got) begin
            @(posedge Clk);
            #1;
            cnt++;
            trig = '0;
            if (mix_valid) begin
                got = 1'b1;
                lat = cnt;
            end else if (busy && !inj) begin
                inj = 1'b1;
                inj_cnt = cnt;
                trig = bt;
                if (dbl) lrclk = 1'b0;
            end else if (dbl && inj && cnt == inj_cnt + 3) begin
                lrclk = 1'b1;
            end
        end
        trig  = '0;
        lrclk = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (mix_sample !== 16'h0) begin n_fail++; $display("FAIL reset mix_sample: got %h, required 0000", mix_sample); end
        n_tests++; if (mix_valid !== 1'b0) begin n_fail++; $display("FAIL reset mix_valid: got %b, required 0", mix_valid); end
        n_tests++; if (rom_rd !== 1'b0) begin n_fail++; $display("FAIL reset rom_rd: got %b, required 0", rom_rd); end
        n_tests++; if (rom_addr !== 16'h0) begin n_fail++; $display("FAIL reset rom_addr: got %h, required 0000", rom_addr); end
        n_tests++; if (voice_active !== 4'h0) begin n_fail++; $display("FAIL reset voice_active: got %b, required 0000", voice_active); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, required 0", busy); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset overrun: got %b, required 0", overrun); end
    endtask

    task automatic test_idle_frames();
        int lat;
        logic got;
        for (int f = 0; f < 3; f++) begin
            exp_mix.push_back(16'h0000);
            run_frame(4'h0, 1'b0, lat, got);
            n_tests++;
            if (!got || lat != 9) begin
                n_fail++;
                $display("FAIL idle latency frame %0d: got %0d (seen %b), required 9", f, lat, got);
            end
            n_tests++;
            if (voice_active !== 4'h0) begin
                n_fail++;
                $display("FAIL idle voice_active: got %b, required 0000", voice_active);
            end
        end
    endtask

    task automatic test_single_voice();
        int lat;
        logic got;
        int exp_lat [4] = '{11, 11, 11, 9};
        logic [3:0] exp_act [4] = '{4'h1, 4'h1, 4'h0, 4'h0};
        do_reset();
        set_voice(0, 16'h0100, 16'd3);
        pulse(4'h1, 4'h0);
        n_tests++;
        if (voice_active !== 4'h1) begin n_fail++; $display("FAIL single trig voice_active: got %b, required 0001", voice_active); end
        exp_addr.push_back(16'h0100); exp_addr.push_back(16'h0101); exp_addr.push_back(16'h0102);
        exp_mix.push_back(16'h0400); exp_mix.push_back(16'h0800);
        exp_mix.push_back(16'h1FC0); exp_mix.push_back(16'h0000);
        for (int f = 0; f < 4; f++) begin
            run_frame(4'h0, 1'b0, lat, got);
            n_tests++;
            if (!got || lat != exp_lat[f]) begin
                n_fail++;
                $display("FAIL single latency frame %0d: got %0d (seen %b), required %0d", f, lat, got, exp_lat[f]);
            end
            n_tests++;
            if (voice_active !== exp_act[f]) begin
                n_fail++;
                $display("FAIL single voice_active frame %0d: got %b, required %b", f, voice_active, exp_act[f]);
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        logic got;
        do_reset();
        rom_fill = 8'h80;
        for (int i = 0; i < 4; i++) begin
            set_voice(i, 16'h2000 + 16'(i * 16), 16'd10);
            exp_addr.push_back(16'h2000 + 16'(i * 16));
        end
        pulse(4'hF, 4'h0);
        n_tests++;
        if (voice_active !== 4'hF) begin n_fail++; $display("FAIL sat voice_active: got %b, required 1111", voice_active); end
        exp_mix.push_back(16'h8000);
        run_frame(4'h0, 1'b0, lat, got);
        n_tests++;
        if (!got || lat != 17) begin n_fail++; $display("FAIL sat latency: got %0d (seen %b), required 17", lat, got); end
    endtask

    task automatic test_mid_frame_trig();
        int lat;
        logic got;
        do_reset();
        rom_fill = 8'h01;
        set_voice(0, 16'h0300, 16'd4);
        pulse(4'h1, 4'h0);
        set_voice(2, 16'h0500, 16'd2);
        exp_addr.push_back(16'h0300);
        exp_mix.push_back(16'h0040);
        run_frame(4'b0100, 1'b0, lat, got);
        n_tests++;
        if (!got || lat != 11) begin n_fail++; $display("FAIL midtrig latency1: got %0d (seen %b), required 11", lat, got); end
        n_tests++;
        if (voice_active !== 4'b0101) begin n_fail++; $display("FAIL midtrig voice_active: got %b, required 0101", voice_active); end
        exp_addr.push_back(16'h0301); exp_addr.push_back(16'h0500);
        exp_mix.push_back(16'h0080);
        run_frame(4'h0, 1'b0, lat, got);
        n_tests++;
        if (!got || lat != 13) begin n_fail++; $display("FAIL midtrig latency2: got %0d (seen %b), required 13", lat, got); end
    endtask

    task automatic test_trig_stop();
        int lat;
        logic got;
        do_reset();
        rom_fill = 8'h02;
        set_voice(1, 16'h0700, 16'd5);
        pulse(4'b0010, 4'b0010);
        n_tests++;
        if (voice_active !== 4'b0010) begin n_fail++; $display("FAIL trigstop voice_active: got %b, required 0010", voice_active); end
        exp_addr.push_back(16'h0700);
        exp_mix.push_back(16'h0080);
        run_frame(4'h0, 1'b0, lat, got);
        n_tests++;
        if (!got || lat != 11) begin n_fail++; $display("FAIL trigstop latency: got %0d (seen %b), required 11", lat, got); end
        pulse(4'h0, 4'b0010);
        n_tests++;
        if (voice_active !== 4'h0) begin n_fail++; $display("FAIL stop voice_active: got %b, required 0000", voice_active); end
        exp_mix.push_back(16'h0000);
        run_frame(4'h0, 1'b0, lat, got);
        n_tests++;
        if (!got || lat != 9) begin n_fail++; $display("FAIL stop latency: got %0d (seen %b), required 9", lat, got); end
    endtask

    task automatic test_overrun_and_reset();
        int lat;
        int cnt;
        int seen;
        logic got;
        do_reset();
        rom_fill = 8'h00;
        for (int i = 0; i < 4; i++) begin
            set_voice(i, 16'h0040 + 16'(i), 16'd8);
            exp_addr.push_back(16'h0040 + 16'(i));
        end
        pulse(4'hF, 4'h0);
        exp_mix.push_back(16'h0000);
        run_frame(4'h0, 1'b1, lat, got);
        n_tests++;
        if (!got || lat != 17) begin n_fail++; $display("FAIL overrun latency: got %0d (seen %b), required 17", lat, got); end
        n_tests++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun set: got %b, required 1", overrun); end
        for (int i = 0; i < 4; i++) exp_addr.push_back(16'h0041 + 16'(i));
        exp_mix.push_back(16'h0000);
        run_frame(4'h0, 1'b0, lat, got);
        n_tests++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun sticky: got %b, required 1", overrun); end
        // Abort a frame with reset while voice 0's fetch is on the bus.
        exp_addr.push_back(16'h0042);
        lrclk = 1'b1;
        cnt = 0;
        while (!busy && cnt < 50) begin
            @(posedge Clk);
            #1;
            cnt++;
        end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset busy start: got %b, required 1", busy); end
        @(negedge Clk);
        Reset_n = 1'b0;
        lrclk   = 1'b0;
        @(posedge Clk);
        #1;
        n_tests++; if (rom_rd !== 1'b0) begin n_fail++; $display("FAIL midreset rom_rd: got %b, required 0", rom_rd); end
        n_tests++; if (rom_addr !== 16'h0) begin n_fail++; $display("FAIL midreset rom_addr: got %h, required 0000", rom_addr); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b, required 0", busy); end
        n_tests++; if (voice_active !== 4'h0) begin n_fail++; $display("FAIL midreset voice_active: got %b, required 0000", voice_active); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midreset overrun: got %b, required 0", overrun); end
        Reset_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge Clk);
            #1;
            if (mix_valid) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL midreset mix_valid: got %0d pulses, required 0", seen); end
    endtask

    initial begin
        test_reset();
        test_idle_frames();
        test_single_voice();
        test_saturation();
        test_mid_frame_trig();
        test_trig_stop();
        test_overrun_and_reset();
        n_tests++;
        if (exp_addr.size() != 0) begin n_fail++; $display("FAIL leftover rom reads: got %0d outstanding, required 0", exp_addr.size()); end
        n_tests++;
        if (exp_mix.size() != 0) begin n_fail++; $display("FAIL leftover mix samples: got %0d outstanding, required 0", exp_mix.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_voice_scheduler.md
Name: audio_voice_scheduler

Overview:
- Polyphonic sound-effect scheduler feeding the I2S serializer.
- Up to NUM_VOICES voices share one single-port sample ROM. Each voice is a triggered one-shot region: a start address plus a length.
- Once per codec LRCLK frame, the block visits voices round-robin, fetches one sample per active voice, and sums them with saturation.
- It presents one signed mixed sample to the i2s block's data input.

Parameters:
- NUM_VOICES, 4, number of voice slots
- ADDR_W, 16, sample ROM address width
- SAMPLE_W, 8, ROM sample width (signed two's complement)
- OUT_W, 16, mixed output sample width
- ROM_LAT, 1, ROM read latency in Clk cycles (1..3)

Ports:
- Clk  in  1  system clock (MAX10_CLK1_50 domain)
- Reset_n  in  1  synchronous active-low reset
- lrclk  in  1  codec LRCLK; asynchronous to Clk
- trig  in  NUM_VOICES  per-voice start pulse
- trig_addr  in  NUM_VOICES*ADDR_W  per-voice start address; voice i uses slice [i*ADDR_W +: ADDR_W]
- trig_len  in  NUM_VOICES*ADDR_W  per-voice length in samples, same slicing
- stop  in  NUM_VOICES  per-voice stop pulse
- rom_rd  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  SAMPLE_W  ROM read data, valid ROM_LAT cycles after rom_rd
- mix_sample  out  OUT_W  signed mixed sample; holds between frames
- mix_valid  out  1  one-cycle pulse when mix_sample updates
- voice_active  out  NUM_VOICES  per-voice playing flag
- busy  out  1  frame mix in progress
- overrun  out  1  sticky; a frame tick arrived while busy

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low. Reset_n=0 at a rising Clk edge clears every register. All outputs read 0 after reset. State returns to IDLE; the synchronizer flops clear to 0.
- Frame tick: lrclk passes through a 2-FF synchronizer plus an edge register. tick = synchronized rising edge, one Clk pulse, 3 cycles after the lrclk edge.
- FSM states: IDLE, ISSUE, WAIT, ACC, DONE.
  - IDLE: on tick, clear acc, set idx=0, assert busy, go to ISSUE.
  - ISSUE: if voice_active[idx], drive rom_rd=1 and rom_addr=base[idx]+pos[idx] (mod 2^ADDR_W) for exactly one cycle, then go to WAIT. If not active, advance idx with no ROM access.
  - WAIT: hold for ROM_LAT cycles, sampling rom_data on the last one, then go to ACC.
  - ACC:
    - acc += sign_extend(rom_data) << (OUT_W-SAMPLE_W-2).
    - pos[idx] += 1.
    - If pos[idx]+1 == len[idx], clear voice_active[idx] (this was the last sample).
    - Advance idx.
  - After idx = NUM_VOICES-1 is processed, go to DONE.
  - DONE: mix_sample <= saturate(acc) to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; pulse mix_valid; clear busy; apply pending triggers/stops; go to IDLE.
- Accumulator: signed, OUT_W+clog2(NUM_VOICES) bits wide. It never wraps; saturation is applied only at DONE.
- Frame latency: tick to mix_valid is 2 + sum over voices (active: 2+ROM_LAT; inactive: 1) cycles. With defaults and all voices active this is 14 cycles, well below the ~1041-cycle frame.
- All-idle frame: mix_valid still pulses and mix_sample = 0.
- Trigger/stop while IDLE: trig[i] loads base=trig_addr slice, len=trig_len slice, pos=0, and sets active=(len!=0). stop[i] clears active.
- Trigger/stop while busy: requests latch into pending registers, applied at DONE, so the frame in progress is unaffected.
- Trigger overrides: trig and stop on the same voice in the same cycle → trig wins. Retriggering an active voice restarts it from pos 0. A later trig for the same voice within one busy window overwrites the earlier one.
- trig with len=0: voice becomes or stays inactive.
- Tick while busy: the tick is dropped and overrun is set. overrun clears only on reset.
- Reset mid-frame: frame aborted, no mix_valid, rom_rd deasserts next cycle, all voices inactive, pending requests discarded.

Decomposition:
- Package audio_pkg:
  - state enum typedef (IDLE..DONE)
  - SAMPLE_SHIFT = OUT_W-SAMPLE_W-2
  - saturation limit constants
  - the voice record typedef {base, len, pos, active}
- One sub-module, lrclk_edge_sync: 2-FF synchronizer plus rising-edge pulse, clocked by Clk with synchronous active-low reset.

Test Plan:
- Reset then idle lrclk toggling at 48 kHz → mix_valid pulses once per frame, mix_sample=0, rom_rd never asserted, voice_active=0.
- trig[0] with addr=0x0100, len=3; ROM returns 0x10, 0x20, 0x7F → rom_addr sequence 0x100, 0x101, 0x102 over three frames. mix_sample = 0x0400, 0x0800, 0x1FC0. voice_active[0] clears after the third frame; the fourth frame gives 0.
- All 4 voices triggered, ROM returns 0x80 (-128) for every address → mix_sample = -32768 (0x8000) with no wrap; 14 cycles from tick to mix_valid.
- trig[2] asserted mid-frame while busy → current frame's rom_addr excludes voice 2. voice_active[2] rises at DONE; voice 2 is fetched the next frame with pos=0.
- trig[1] and stop[1] in the same IDLE cycle (len=5) → voice 1 active. A later lone stop[1] → inactive next frame with no ROM read for idx 1.
- Force a tick while busy → overrun=1 and sticky; the frame completes normally. Reset_n=0 mid-frame → all outputs 0, no mix_valid.
